shift_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one registered barrel shifter (one-cycle latency, signed 8-bit power: non-negative shifts left, negative shifts right by its magnitude) among several neuron-datapath requesters. It accepts one request at a time over a valid/ready handshake and drives the shared shifter's base/power inputs. It captures the shifter result and returns it, tagged with the requester index, over a valid/ready response channel. It sits between the per-neuron weight-scaling logic and the single shifter instance.

---
 rtl/shift_arbiter.sv | 140 ++++++++++++++
 tb/tb_shift_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shift_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one registered barrel
//            shifter among NUM_REQ requesters. Optional SHIFT_ARB_RANGE_CHK_EN
//            lets out-of-range shifts bypass the shifter.
// Revision : 1.0 - initial release
// ============================================================================
module shift_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_base,
    input  logic [8*NUM_REQ-1:0]  req_power,
    output logic [31:0]           sh_base,
    output logic [7:0]            sh_power,
    input  logic [31:0]           sh_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [31:0]           rsp_result,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IDW-1:0] r_last_grant;
    logic [IDW-1:0] r_id;
    logic [31:0]    r_base;
    logic [7:0]     r_power;
    logic [31:0]    r_result;
    logic [IDW-1:0] w_grant;
    logic [IDW-1:0] w_cand;
    logic           w_found;
    logic           w_accept;
    logic [31:0]    w_sel_base;
    logic [7:0]     w_sel_power;

    // Walk from the far end back toward last_grant+1 so the nearest set bit wins.
    always_comb begin
        w_grant = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = IDW'((int'(r_last_grant) + k) % NUM_REQ);
            if (req_valid[w_cand]) begin
                w_grant = w_cand;
                w_found = 1'b1;
            end
        end
    end

    assign w_sel_base  = req_base[{w_grant, 5'd0} +: 32];
    assign w_sel_power = req_power[{w_grant, 3'd0} +: 8];
    assign w_accept    = (r_state == IDLE) && w_found && rst_n;

`ifdef SHIFT_ARB_RANGE_CHK_EN
    logic w_big;
    // Magnitude >= 32: 0x20..0x7F positive, 0x80..0xE0 negative.
    assign w_big = w_sel_power[7] ? (w_sel_power <= 8'hE0) : (w_sel_power >= 8'h20);
`endif

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    req_ready[w_grant] = 1'b1;
`ifdef SHIFT_ARB_RANGE_CHK_EN
                    w_state_nxt = w_big ? RESP : ISSUE;
`else
                    w_state_nxt = ISSUE;
`endif
                end
            end
            ISSUE:   w_state_nxt = WAIT;
            WAIT:    w_state_nxt = RESP;
            RESP:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= IDW'(NUM_REQ - 1);
            r_id         <= '0;
            r_base       <= '0;
            r_power      <= '0;
            r_result     <= '0;
        end else begin
            if (w_accept) begin
                r_id         <= w_grant;
                r_last_grant <= w_grant;
`ifdef SHIFT_ARB_RANGE_CHK_EN
                if (w_big) begin
                    r_result <= '0;
                end else begin
                    r_base  <= w_sel_base;
                    r_power <= w_sel_power;
                end
`else
                r_base  <= w_sel_base;
                r_power <= w_sel_power;
`endif
            end
            if (r_state == WAIT) begin
                r_result <= sh_result;
            end
        end
    end

    assign sh_base    = r_base;
    assign sh_power   = r_power;
    assign rsp_valid  = (r_state == RESP);
    assign rsp_id     = r_id;
    assign rsp_result = r_result;
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_arbiter
// Purpose  : Randomized and directed bench for shift_arbiter against a
//            transaction-level reference model (honours SHIFT_ARB_RANGE_CHK_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_arbiter;
    localparam int N = 4;
`ifdef SHIFT_ARB_RANGE_CHK_EN
    localparam bit RCHK = 1'b1;
`else
    localparam bit RCHK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_base;
    logic [8*N-1:0]  req_power;
    logic [31:0]     sh_base;
    logic [7:0]      sh_power;
    logic [31:0]     sh_result;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [31:0]     rsp_result;
    logic            busy;

    shift_arbiter #(.NUM_REQ(N), .IDW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_base(req_base), .req_power(req_power),
        .sh_base(sh_base), .sh_power(sh_power), .sh_result(sh_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input logic [31:0] b, input logic [7:0] p);
        int sp;
        sp = int'($signed(p));
        if (sp >= 32 || sp <= -32) return 32'd0;
        if (sp >= 0) return b << sp;
        return b >> (-sp);
    endfunction

    function automatic bit is_big(input logic [7:0] p);
        int sp;
        sp = int'($signed(p));
        return (sp >= 32 || sp <= -32);
    endfunction

    // Shared shifter: one registered stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sh_result <= '0;
        else        sh_result <= ref_shift(sh_base, sh_power);
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: one outstanding transaction, round-robin pointer.
    int          cyc = 0;
    bit          m_out;
    int          m_acc, m_lat, m_last;
    logic [1:0]  m_id;
    logic [31:0] m_res, m_sh_base;
    logic [7:0]  m_sh_pow;
    logic [N-1:0] m_gmask;
    bit          hold_valid = 1'b0;
    int          grants[$];
    int          gcyc[$];
    // Observations taken from the DUT for directed checks.
    bit          hs, prev_rv;
    int          hs_cyc, dut_acc, got_lat;
    logic [1:0]  got_id;
    logic [31:0] got_res;

    task automatic model_reset();
        m_out = 0; m_last = N - 1; m_sh_base = '0; m_sh_pow = '0;
        m_gmask = '0; prev_rv = 0; hs = 0;
    endtask

    task automatic set_req(input int i, input logic [31:0] b, input logic [7:0] p);
        req_valid[i]        = 1'b1;
        req_base[32*i +: 32] = b;
        req_power[8*i +: 8]  = p;
    endtask

    // Entered at posedge+1 with inputs driven; samples mid-cycle, returns at next posedge+1.
    task automatic tick();
        logic [N-1:0] exp_ready;
        int  g;
        bit  exp_rv;
        logic [7:0] p;
        #4;
        exp_ready = '0;
        g = -1;
        if (!m_out) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_last + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        exp_rv = m_out && ((cyc - m_acc) >= m_lat);
        chk("req_ready", req_ready, exp_ready);
        chk("busy", busy, m_out);
        chk("rsp_valid", rsp_valid, exp_rv);
        chk("sh_base", sh_base, m_sh_base);
        chk("sh_power", sh_power, m_sh_pow);
        if (exp_rv) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_result", rsp_result, m_res);
        end
        hs = 0;
        if (rsp_valid && !prev_rv) got_lat = cyc - dut_acc;
        prev_rv = rsp_valid;
        if (rsp_valid && rsp_ready) begin
            hs = 1; hs_cyc = cyc; got_id = rsp_id; got_res = rsp_result;
        end
        if (req_ready != '0) dut_acc = cyc;
        m_gmask = exp_ready;
        if (g >= 0) begin
            p = req_power[8*g +: 8];
            m_out = 1; m_acc = cyc; m_id = 2'(g); m_last = g;
            m_res = ref_shift(req_base[32*g +: 32], p);
            m_lat = (RCHK && is_big(p)) ? 1 : 3;
            if (!(RCHK && is_big(p))) begin
                m_sh_base = req_base[32*g +: 32];
                m_sh_pow  = p;
            end
            grants.push_back(g);
            gcyc.push_back(cyc);
        end else if (exp_rv && rsp_ready) begin
            m_out = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!hold_valid) req_valid = req_valid & ~m_gmask;
    endtask

    task automatic run_txn(input int maxc);
        bit done;
        done = 0;
        for (int k = 0; k < maxc && !done; k++) begin
            tick();
            if (hs) done = 1;
        end
        if (!done) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [7:0] rand_pow();
        if ($urandom_range(0, 3) == 0) return 8'($urandom);
        return 8'(int'($urandom_range(0, 72)) - 36);
    endfunction

    initial begin
        rst_n = 1'b0; req_valid = '0; req_base = '0; req_power = '0; rsp_ready = 1'b0;
        model_reset();
        #12;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_result", rsp_result, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single request granted in the first cycle after reset release.
        rsp_ready = 1'b1;
        set_req(0, 32'h0000_0010, 8'd3);
        run_txn(10);
        chk("t1_id", got_id, 0);
        chk("t1_res", got_res, 32'h0000_0080);
        chk("t1_lat", got_lat, 3);

        set_req(2, 32'h8000_0000, 8'hFC);
        run_txn(10);
        chk("t2_id", got_id, 2);
        chk("t2_res", got_res, 32'h0800_0000);

        // Backpressure with requester 1 waiting.
        rsp_ready = 1'b0;
        set_req(0, 32'h0000_1234, 8'd0);
        tick();
        set_req(1, 32'h0000_0001, 8'd1);
        repeat (7) tick();
        rsp_ready = 1'b1;
        tick();
        chk("t3_hs", hs, 1);
        chk("t3_res", got_res, 32'h0000_1234);
        tick();
        chk("t3_grant1", grants[$], 1);
        chk("t3_gap", gcyc[$] - hs_cyc, 1);
        run_txn(10);
        chk("t3_res1", got_res, 32'h2);

        // Range boundary and control case.
        set_req(1, 32'hFFFF_FFFF, 8'd32);
        run_txn(10);
        chk("t4_res", got_res, 0);
        chk("t4_lat", got_lat, RCHK ? 1 : 3);
        set_req(1, 32'hFFFF_FFFF, 8'd31);
        run_txn(10);
        chk("t5_res", got_res, 32'h8000_0000);
        chk("t5_lat", got_lat, 3);

        // Reset during WAIT, then all four requesters valid.
        set_req(3, 32'h0000_ABCD, 8'd2);
        tick();
        tick();
        for (int i = 0; i < N; i++) set_req(i, 32'(i + 5), 8'(i));
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sh_base", sh_base, 0);
        chk("mid_rst_result", rsp_result, 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        hold_valid = 1'b1;
        grants.delete();
        gcyc.delete();
        repeat (17) tick();
        for (int i = 0; i < 5; i++) chk("rr_order", grants[i], i % N);
        for (int i = 1; i < 5; i++) chk("rr_period", gcyc[i] - gcyc[i-1], 4);
        hold_valid = 1'b0;
        req_valid = '0;
        for (int k = 0; k < 10 && m_out; k++) tick();

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0)
                    set_req(i, 32'($urandom), rand_pow());
                else if (req_valid[i] && $urandom_range(0, 19) == 0)
                    req_valid[i] = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 10 && m_out; k++) tick();
        chk("drain_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
